dac_serial_tx: RTL and testbench

DAC_SERIAL_TX -- requirements
Module: dac_serial_tx

---
 rtl/dac_serial_tx.sv | 115 +++++++++++
 tb/tb_dac_serial_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_serial_tx.sv
// Serial transmitter for a SPI-style DAC: frames one WIDTH-bit word MSB first
// under an active-low chip select, followed by a fixed inter-frame gap.
module dac_serial_tx #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             dac_clk,
  output logic             cs_n,
  output logic             sdo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
  localparam int unsigned BIT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             tick;
  logic             dac_clk_d, cs_n_d, sdo_d, busy_d, done_d;

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      dac_clk <= 1'b0;
      cs_n    <= 1'b1;
      sdo     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      dac_clk <= dac_clk_d;
      cs_n    <= cs_n_d;
      sdo     <= sdo_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register
  // in the same edge as the state change.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    div_d   = '0;
    tick    = (state_q == GAP) ? (div_q == GAP_LAST) : (div_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          shreg_d = din;
          bit_d   = '0;
        end
      end
      SETUP:    if (tick) state_d = SHIFT_HI;
      SHIFT_HI: begin
        if (tick) begin
          state_d = SHIFT_LO;
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
      end
      SHIFT_LO: begin
        if (tick) begin
          if (bit_q == BIT_LAST) begin
            state_d = HOLD;
          end else begin
            state_d = SHIFT_HI;
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
      HOLD:     if (tick) state_d = GAP;
      GAP:      if (tick) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (state_d != IDLE && state_d == state_q) begin
      div_d = div_q + DIV_W'(1);
    end

    cs_n_d    = (state_d == IDLE) || (state_d == GAP);
    dac_clk_d = (state_d == SHIFT_HI);
    sdo_d     = (state_d == IDLE) ? 1'b0 : shreg_d[WIDTH-1];
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == HOLD) && (state_d == GAP);
  end

endmodule

// File: tb/tb_dac_serial_tx.sv
// Self-checking bench for dac_serial_tx: default instance plus a WIDTH=10,
// CLK_DIV=2 instance, checked against frame-level timing and bit rules.
module tb_dac_serial_tx;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 25;
  localparam int unsigned W2 = 10;
  localparam int unsigned D2 = 2;
  localparam int LOW_LEN  = (2 * W + 2) * D;
  localparam int BUSY_LEN = (2 * W + 4) * D;
  localparam int LIMIT    = 2000;

  logic clk = 1'b0;
  logic rst, start, start2;
  logic [W-1:0]  din;
  logic [W2-1:0] din2;
  logic dac_clk, cs_n, sdo, busy, done;
  logic dac_clk2, cs_n2, sdo2, busy2, done2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dac_serial_tx #(.WIDTH(W), .CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .dac_clk(dac_clk), .cs_n(cs_n), .sdo(sdo), .busy(busy), .done(done)
  );

  dac_serial_tx #(.WIDTH(W2), .CLK_DIV(D2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .din(din2),
    .dac_clk(dac_clk2), .cs_n(cs_n2), .sdo(sdo2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder for the default instance: one entry per observed event.
  logic pclk = 1'b0, pcs = 1'b1, psdo = 1'b0, pbusy = 1'b0;
  int run = 0, phase_err = 0, sdo_err = 0;
  int bits_q[$], rise_q[$], fall_q[$], csr_q[$], done_q[$], bfall_q[$];

  always @(negedge clk) begin
    if (cs_n === 1'b0 && pcs === 1'b1) begin
      fall_q.push_back(cyc);
      run = 0;
    end
    if (cs_n === 1'b1 && pcs === 1'b0) csr_q.push_back(cyc);
    if (dac_clk === pclk) begin
      run++;
    end else begin
      if (cs_n === 1'b0 && run != int'(D)) phase_err++;
      if (dac_clk === 1'b1) begin
        bits_q.push_back(int'(sdo));
        rise_q.push_back(cyc);
      end
      run = 1;
    end
    if (dac_clk === 1'b1 && pclk === 1'b1 && sdo !== psdo) sdo_err++;
    if (done === 1'b1) done_q.push_back(cyc);
    if (busy === 1'b0 && pbusy === 1'b1) bfall_q.push_back(cyc);
    pclk = dac_clk; pcs = cs_n; psdo = sdo; pbusy = busy;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    bits_q.delete(); rise_q.delete(); fall_q.delete();
    csr_q.delete(); done_q.delete(); bfall_q.delete();
    phase_err = 0; sdo_err = 0;
  endtask

  function automatic int qat(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < LIMIT) begin
      din = W'($urandom);
      step();
      n++;
    end
    chk({tag, "_idle_bound"}, 32'(n < LIMIT), 1);
  endtask

  // One frame with start re-pulsed and din scrambled mid-frame.
  task automatic frame(input logic [W-1:0] word, input string tag);
    int acc, n;
    clear_mon();
    din = word; start = 1'b1; acc = cyc + 1;
    step();
    n = 0;
    while (busy !== 1'b0 && n < LIMIT) begin
      start = (cyc == acc + 199);
      din = W'($urandom);
      step();
      n++;
    end
    start = 1'b0;
    chk({tag, "_bound"}, 32'(n < LIMIT), 1);
    chk({tag, "_nbits"}, bits_q.size(), W);
    for (int i = 0; i < int'(W); i++)
      chk($sformatf("%s_bit%0d", tag, i), qat(bits_q, i), int'(word[W-1-i]));
    chk({tag, "_cs_fall"}, qat(fall_q, 0), acc);
    chk({tag, "_first_rise"}, qat(rise_q, 0), acc + int'(D));
    chk({tag, "_cs_low_len"}, qat(csr_q, 0) - qat(fall_q, 0), LOW_LEN);
    chk({tag, "_ndone"}, done_q.size(), 1);
    chk({tag, "_done_at"}, qat(done_q, 0), acc + LOW_LEN);
    chk({tag, "_busy_fall"}, qat(bfall_q, 0), acc + BUSY_LEN);
    chk({tag, "_phase"}, phase_err, 0);
    chk({tag, "_sdo_hi"}, sdo_err, 0);
    step();
    chk({tag, "_no_restart"}, {cs_n, busy}, 2'b10);
  endtask

  task automatic frame2(input logic [W2-1:0] word, input string tag);
    int acc, rises, n, done_at;
    logic p;
    logic [W2-1:0] got;
    din2 = word; start2 = 1'b1; acc = cyc + 1;
    step();
    start2 = 1'b0;
    rises = 0; n = 0; done_at = -1; got = '0; p = 1'b0;
    while (busy2 !== 1'b0 && n < LIMIT) begin
      if (dac_clk2 === 1'b1 && p === 1'b0) begin
        got = {got[W2-2:0], sdo2};
        rises++;
      end
      if (done2 === 1'b1) done_at = cyc;
      p = dac_clk2;
      step();
      n++;
    end
    chk({tag, "_rises"}, rises, W2);
    chk({tag, "_word"}, 32'(got), 32'(word));
    chk({tag, "_done_at"}, done_at, acc + int'((2 * W2 + 2) * D2));
    chk({tag, "_busy_fall"}, cyc, acc + int'((2 * W2 + 4) * D2));
  endtask

  initial begin
    int acc, n;
    logic [W-1:0] w;
    rst = 1'b1; start = 1'b1; start2 = 1'b1; din = '1; din2 = '1;
    repeat (3) step();
    chk("rst_outs", {cs_n, dac_clk, sdo, busy, done}, 5'b10000);
    chk("rst_outs2", {cs_n2, dac_clk2, sdo2, busy2, done2}, 5'b10000);
    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    step();
    chk("idle_after_rst", {cs_n, busy}, 2'b10);

    frame(8'h66, "f66");
    frame(8'hAA, "fAA");
    for (int k = 0; k < 3; k++) begin
      w = W'($urandom);
      repeat ($urandom_range(0, 3)) step();
      frame(w, $sformatf("rnd%0d", k));
    end

    // Start held high: second word offered on the first idle cycle.
    clear_mon();
    din = 8'h66; start = 1'b1; acc = cyc + 1;
    step();
    wait_idle("b2b1");
    din = 8'hAA;
    step();
    wait_idle("b2b2");
    start = 1'b0;
    chk("b2b_nbits", bits_q.size(), 2 * W);
    for (int i = 0; i < int'(W); i++) begin
      chk($sformatf("b2b_a_bit%0d", i), qat(bits_q, i), int'(w8(8'h66, i)));
      chk($sformatf("b2b_b_bit%0d", i), qat(bits_q, i + int'(W)), int'(w8(8'hAA, i)));
    end
    chk("b2b_ndone", done_q.size(), 2);
    chk("b2b_gap", qat(fall_q, 1) - qat(done_q, 0) - 1, 2 * int'(D));
    chk("b2b_done2", qat(done_q, 1), acc + BUSY_LEN + 1 + LOW_LEN);
    chk("b2b_phase", phase_err, 0);

    // Reset while dac_clk is high on bit 3, with start asserted alongside.
    clear_mon();
    din = 8'hC3; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(bits_q.size() == 4 && dac_clk === 1'b1) && n < LIMIT) begin
      step();
      n++;
    end
    chk("abort_reach", 32'(n < LIMIT), 1);
    rst = 1'b1; start = 1'b1; din = 8'hB5;
    step();
    rst = 1'b0;
    chk("abort_outs", {cs_n, dac_clk, sdo, busy, done}, 5'b10000);
    chk("abort_nodone", done_q.size(), 0);
    clear_mon();
    acc = cyc + 1;
    step();
    start = 1'b0;
    chk("restart_outs", {cs_n, sdo, busy}, 3'b011);
    wait_idle("restart");
    chk("restart_ndone", done_q.size(), 1);
    chk("restart_done_at", qat(done_q, 0), acc + LOW_LEN);
    chk("restart_nbits", bits_q.size(), W);
    for (int i = 0; i < int'(W); i++)
      chk($sformatf("restart_bit%0d", i), qat(bits_q, i), int'(w8(8'hB5, i)));

    frame2(10'h3FF, "w10_ones");
    frame2(W2'($urandom), "w10_rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bit i of an 8-bit word in transmission order (MSB first).
  function automatic logic w8(input logic [7:0] word, input int i);
    return word[7-i];
  endfunction

endmodule
